dmem_readback: RTL and testbench

Read-side counterpart of the CPU's program/data load path. After a program has run, this block walks a contiguous window of the CPU data memory through its synchronous read port and streams the words out on a valid/ready interface, each tagged with its address and a last flag. It sits beside the data memory and replaces hierarchical peeking at memory contents with a cycle-accurate hardware readback path.

---
 rtl/dmem_readback_if.sv | 15 +
 rtl/dmem_readback.sv | 147 ++++++++++++++
 tb/tb_dmem_readback.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_readback_if.sv
// Word stream carried out of the data-memory readback block.
// Each beat has the data word, its memory address and an end-of-window marker.
interface dmem_readback_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic              last;

    modport master (output valid, output data, output addr, output last, input ready);
    modport slave  (input valid, input data, input addr, input last, output ready);
endinterface

// File: rtl/dmem_readback.sv
// Walks a window of data memory through its synchronous read port and streams the words out.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | waiting for start_i; base/length captured on start
//   S_RUN    | issuing reads, buffering returns in a 2-entry FIFO, draining
//   S_FINISH | one-cycle done pulse, then back to S_IDLE
module dmem_readback #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W:0]   length_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              mem_rd_en_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    dmem_readback_if.master   out_if
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   rd_left_q, rd_left_d;
    logic [ADDR_W:0]   out_left_q, out_left_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_addr_q, inflight_addr_d;
    logic [DATA_W-1:0] fifo_data_q [2];
    logic [DATA_W-1:0] fifo_data_d [2];
    logic [ADDR_W-1:0] fifo_addr_q [2];
    logic [ADDR_W-1:0] fifo_addr_d [2];
    logic              wr_idx_q, wr_idx_d;
    logic              rd_idx_q, rd_idx_d;
    logic [1:0]        count_q, count_d;

    logic              fifo_valid;
    logic              pop;
    logic              rd_en;
    logic [2:0]        slots_used;

    assign fifo_valid = (count_q != 2'd0);
    assign pop        = fifo_valid && out_if.ready;

    // A slot freed by this cycle's pop can be reused by this cycle's read,
    // which is what keeps the stream at one word per cycle.
    assign slots_used = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign rd_en      = (state_q == S_RUN) && (rd_left_q != '0) && (slots_used < 3'd2);

    always_comb begin
        state_d         = state_q;
        rd_ptr_d        = rd_ptr_q;
        rd_left_d       = rd_left_q;
        out_left_d      = out_left_q;
        inflight_d      = 1'b0;
        inflight_addr_d = inflight_addr_q;
        fifo_data_d     = fifo_data_q;
        fifo_addr_d     = fifo_addr_q;
        wr_idx_d        = wr_idx_q;
        rd_idx_d        = rd_idx_q;
        count_d         = count_q + {1'b0, inflight_q} - {1'b0, pop};

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    rd_ptr_d   = base_addr_i;
                    rd_left_d  = length_i;
                    out_left_d = length_i;
                    state_d    = (length_i == '0) ? S_FINISH : S_RUN;
                end
            end
            S_RUN: begin
                if (rd_en) begin
                    rd_ptr_d        = rd_ptr_q + 1'b1;
                    rd_left_d       = rd_left_q - CNT_ONE;
                    inflight_d      = 1'b1;
                    inflight_addr_d = rd_ptr_q;
                end
                if (pop) begin
                    out_left_d = out_left_q - CNT_ONE;
                    if (out_left_q == CNT_ONE) begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        // Read data is only valid the cycle after the strobe, so capture it then.
        if (inflight_q) begin
            fifo_data_d[wr_idx_q] = mem_rdata_i;
            fifo_addr_d[wr_idx_q] = inflight_addr_q;
            wr_idx_d              = ~wr_idx_q;
        end
        if (pop) begin
            rd_idx_d = ~rd_idx_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            rd_ptr_q        <= '0;
            rd_left_q       <= '0;
            out_left_q      <= '0;
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
            fifo_data_q[0]  <= '0;
            fifo_data_q[1]  <= '0;
            fifo_addr_q[0]  <= '0;
            fifo_addr_q[1]  <= '0;
            wr_idx_q        <= 1'b0;
            rd_idx_q        <= 1'b0;
            count_q         <= 2'd0;
        end else begin
            state_q         <= state_d;
            rd_ptr_q        <= rd_ptr_d;
            rd_left_q       <= rd_left_d;
            out_left_q      <= out_left_d;
            inflight_q      <= inflight_d;
            inflight_addr_q <= inflight_addr_d;
            fifo_data_q     <= fifo_data_d;
            fifo_addr_q     <= fifo_addr_d;
            wr_idx_q        <= wr_idx_d;
            rd_idx_q        <= rd_idx_d;
            count_q         <= count_d;
        end
    end

    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = (state_q == S_FINISH);
    assign mem_rd_en_o  = rd_en;
    assign mem_addr_o   = rd_en ? rd_ptr_q : '0;

    assign out_if.valid = fifo_valid;
    assign out_if.data  = fifo_data_q[rd_idx_q];
    assign out_if.addr  = fifo_addr_q[rd_idx_q];
    assign out_if.last  = fifo_valid && (out_left_q == CNT_ONE);

endmodule

// File: tb/tb_dmem_readback.sv
// Directed bench for dmem_readback: sorted image, backpressure, wrap, zero/full length,
// mid-run reset and start-while-busy, all against hand-computed expected streams.
module tb_dmem_readback;
    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base;
    logic [AW:0]   len;
    logic          busy, done, rd_en;
    logic [AW-1:0] maddr;
    logic [DW-1:0] rdata;

    always #5 clk = ~clk;

    dmem_readback_if #(.ADDR_W(AW), .DATA_W(DW)) sif ();

    dmem_readback #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start),
        .base_addr_i (base),
        .length_i    (len),
        .busy_o      (busy),
        .done_o      (done),
        .mem_rd_en_o (rd_en),
        .mem_addr_o  (maddr),
        .mem_rdata_i (rdata),
        .out_if      (sif)
    );

    logic [DW-1:0] mem [1024];
    always @(posedge clk) begin
        if (rd_en) rdata <= mem[maddr];
    end

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] exp_d [1024];
    logic [AW-1:0] exp_a [1024];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic ready_pat(input int mode, input int c);
        if (mode == 1) return ((c % 4) == 0) || ((c % 4) == 3);
        return 1'b1;
    endfunction

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_busy"},  busy,      0);
        check_eq({tag, "_done"},  done,      0);
        check_eq({tag, "_rden"},  rd_en,     0);
        check_eq({tag, "_maddr"}, maddr,     0);
        check_eq({tag, "_valid"}, sif.valid, 0);
        check_eq({tag, "_data"},  sif.data,  0);
        check_eq({tag, "_addr"},  sif.addr,  0);
        check_eq({tag, "_last"},  sif.last,  0);
    endtask

    // Runs one readback and compares the stream against exp_d/exp_a.
    task automatic run(input logic [AW-1:0] b, input logic [AW:0] l, input int mode,
                       input bit poke, input string nm);
        int k = 0, done_cyc = -1, first_rd = -1, first_val = -1;
        int issued = 0, acc = 0, max_out = 0, busy_low = 0, stall_bad = 0;
        logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
        logic [DW-1:0] pd = '0;
        logic [AW-1:0] pa = '0;
        @(negedge clk);
        start = 1'b1; base = b; len = l; sif.ready = 1'b0;
        @(posedge clk);
        for (int cyc = 0; cyc < int'(l) * 4 + 20; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (poke && cyc == 4) begin
                start = 1'b1; base = b + 10'd7; len = 11'd3;
            end
            sif.ready = ready_pat(mode, cyc);
            #1;
            if (pv && !pr) begin
                if (!(sif.valid && sif.data == pd && sif.addr == pa && sif.last == pl))
                    stall_bad++;
            end
            if (rd_en) begin
                if (first_rd < 0) begin
                    first_rd = cyc;
                    check_eq({nm, "_first_maddr"}, maddr, b);
                end
                issued++;
            end
            if (sif.valid && first_val < 0) first_val = cyc;
            if (!busy) busy_low++;
            if (sif.valid && sif.ready) begin
                if (k < int'(l)) begin
                    check_eq({nm, "_data"}, sif.data, exp_d[k]);
                    check_eq({nm, "_addr"}, sif.addr, exp_a[k]);
                    check_eq({nm, "_last"}, sif.last, (k == int'(l) - 1));
                end
                acc++;
                k++;
            end
            if (issued - acc > max_out) max_out = issued - acc;
            pv = sif.valid; pr = sif.ready; pd = sif.data; pa = sif.addr; pl = sif.last;
            if (done) begin
                done_cyc = cyc;
                break;
            end
        end
        start = 1'b0;
        check_eq({nm, "_words"}, k, l);
        check_eq({nm, "_done_seen"}, (done_cyc >= 0), 1);
        check_eq({nm, "_busy_gap"}, busy_low, 0);
        check_eq({nm, "_stall_stable"}, stall_bad, 0);
        check_eq({nm, "_max_outstanding_le2"}, (max_out <= 2), 1);
        if (l == 0) begin
            check_eq({nm, "_no_rden"}, issued, 0);
            check_eq({nm, "_done_cyc"}, done_cyc, 0);
        end else begin
            check_eq({nm, "_first_rd_cyc"}, first_rd, 0);
            check_eq({nm, "_first_val_cyc"}, first_val, 2);
            check_eq({nm, "_reads"}, issued, l);
            if (mode == 0) check_eq({nm, "_done_cyc"}, done_cyc, int'(l) + 2);
        end
        @(negedge clk);
        #1;
        check_eq({nm, "_busy_after"}, busy, 0);
        check_eq({nm, "_done_after"}, done, 0);
        sif.ready = 1'b0;
    endtask

    task automatic load_sorted_exp(input int first, input int n);
        logic [DW-1:0] img [10];
        img = '{32'd12, 32'd12, 32'd12, 32'd19, 32'd30, 32'd30, 32'd30, 32'd69, 32'd69, 32'd69};
        for (int i = 0; i < n; i++) begin
            exp_d[i] = img[first + i];
            exp_a[i] = AW'(first + i);
        end
    endtask

    initial begin
        int hs;
        logic [DW-1:0] img [10];
        rst = 1'b1; start = 1'b0; base = '0; len = '0; sif.ready = 1'b0;
        img = '{32'd12, 32'd12, 32'd12, 32'd19, 32'd30, 32'd30, 32'd30, 32'd69, 32'd69, 32'd69};
        for (int a = 0; a < 1024; a++) mem[a] = 32'hDEAD_0000 | a;
        for (int a = 0; a < 10; a++) mem[a] = img[a];
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        load_sorted_exp(0, 10);
        run(10'd0, 11'd10, 0, 1'b0, "sorted");
        run(10'd0, 11'd10, 1, 1'b0, "backpressure");
        run(10'd0, 11'd10, 0, 1'b1, "start_busy");
        run(10'd3, 11'd0, 0, 1'b0, "zero_len");

        // Reset after the third handshake while the next read is in flight.
        @(negedge clk);
        start = 1'b1; base = 10'd0; len = 11'd10; sif.ready = 1'b1;
        @(posedge clk);
        hs = 0;
        for (int cyc = 0; cyc < 30 && hs < 3; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (sif.valid && sif.ready) hs++;
        end
        check_eq("midrst_handshakes", hs, 3);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        sif.ready = 1'b0;
        load_sorted_exp(5, 2);
        run(10'd5, 11'd2, 0, 1'b0, "after_rst");

        for (int a = 0; a < 1024; a++) mem[a] = a + 100;
        exp_a[0] = 10'd1022; exp_d[0] = 32'd1122;
        exp_a[1] = 10'd1023; exp_d[1] = 32'd1123;
        exp_a[2] = 10'd0;    exp_d[2] = 32'd100;
        exp_a[3] = 10'd1;    exp_d[3] = 32'd101;
        run(10'd1022, 11'd4, 0, 1'b0, "wrap");

        for (int i = 0; i < 1024; i++) begin
            exp_a[i] = AW'(i);
            exp_d[i] = i + 100;
        end
        run(10'd0, 11'd1024, 0, 1'b0, "full_len");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
